cache_line_arbiter: RTL

//  2:1 arbiter directly upstream of the L2 cacheline adapter. Merges the I-cache miss port
//  (read-only) and the D-cache miss/writeback port (read/write) onto the single 256-bit
//  l2cache_* request interface. Grants are round-robin. The granted request is latched, and
//  the latched copy is held stable on the downstream port until l2cache_resp.

---
 rtl/cache_types.sv | 16 +
 rtl/cache_line_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cache_types.sv
// Shared types for the L2-side cacheline path: arbiter state, port ids and line geometry.
package cache_types;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_port_t;

  localparam int unsigned LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/cache_line_arbiter.sv
// Round-robin 2:1 arbiter merging I-cache and D-cache line misses onto one L2 adapter port.
// The granted request is latched and replayed unchanged until the adapter responds.
module cache_line_arbiter
  import cache_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  input  logic                  icache_read,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic [ADDR_WIDTH-1:0] l2cache_addr,
  output logic                  l2cache_read,
  output logic                  l2cache_write,
  output logic [LINE_WIDTH-1:0] l2cache_wdata,
  input  logic [LINE_WIDTH-1:0] l2cache_rdata,
  input  logic                  l2cache_resp
);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    ADDR_WIDTH'((64'd1 << LINE_OFFSET_BITS) - 64'd1);

  arb_state_t            state_q, state_d;
  arb_port_t             last_q, last_d;
  arb_port_t             grant_q, grant_d;
  arb_port_t             take_port;
  logic                  take;
  logic                  req_i, req_d;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;
  logic [LINE_WIDTH-1:0] lat_wdata;

  // State and grant history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_D;
      grant_q <= ARB_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // Request latch: captured once per grant, frozen while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
    end else if (take) begin
      if (take_port == ARB_I) begin
        lat_addr  <= icache_addr & ~OFFSET_MASK;
        lat_write <= 1'b0;
        lat_wdata <= '0;
      end else begin
        lat_addr  <= dcache_addr & ~OFFSET_MASK;
        lat_write <= dcache_write;
        lat_wdata <= dcache_wdata;
      end
    end
  end

  // Arbitration, next state and response steering
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    take        = 1'b0;
    take_port   = ARB_I;
    icache_resp = 1'b0;
    dcache_resp = 1'b0;
    req_i       = icache_read;
    req_d       = dcache_read | dcache_write;

    case (state_q)
      ARB_IDLE: begin
        if (req_i && req_d) begin
          take      = 1'b1;
          take_port = (last_q == ARB_I) ? ARB_D : ARB_I;
        end else if (req_i) begin
          take      = 1'b1;
          take_port = ARB_I;
        end else if (req_d) begin
          take      = 1'b1;
          take_port = ARB_D;
        end
        if (take) begin
          state_d = ARB_BUSY;
          grant_d = take_port;
          last_d  = take_port;
        end
      end
      ARB_BUSY: begin
        if (l2cache_resp && !rst) begin
          icache_resp = (grant_q == ARB_I);
          dcache_resp = (grant_q == ARB_D);
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign l2cache_addr  = lat_addr;
  assign l2cache_wdata = lat_wdata;
  assign l2cache_read  = (state_q == ARB_BUSY) && !lat_write;
  assign l2cache_write = (state_q == ARB_BUSY) && lat_write;
  assign icache_rdata  = l2cache_rdata;
  assign dcache_rdata  = l2cache_rdata;

  // A response with nothing outstanding means the adapter lost track of a transaction
  assert property (@(posedge clk) disable iff (rst) !(l2cache_resp && state_q == ARB_IDLE))
    else $error("l2cache_resp received while arbiter idle");

endmodule
